// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control path: ALUOp values, R-type funct codes
// and the 4-bit ALU control codes consumed by the ALU bit-slices.
package alu_pkg;

  localparam int FUNCT_W_DEF = 6;
  localparam int CTL_W_DEF   = 4;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

endpackage

// File: rtl/alu_ctl_decode.sv
// ID-stage ALU control decode: ALUOp plus funct to ALU control code,
// overflow-check enable and illegal-funct flag. Purely combinational.
module alu_ctl_decode
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int CTL_W   = 4
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTL_W-1:0]   code,
  output logic               chk,
  output logic               illegal
);

  always_comb begin
    code    = ALU_AND;
    chk     = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_OR:  code = ALU_OR;
      ALUOP_RTYPE: begin
        // Only signed add/sub trap on overflow; unknown funct gives a bubble-like AND code.
        case (funct)
          FUNCT_ADD: begin code = ALU_ADD; chk = 1'b1; end
          FUNCT_SUB: begin code = ALU_SUB; chk = 1'b1; end
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_SLT: code = ALU_SLT;
          FUNCT_XOR: code = ALU_XOR;
          default:   illegal = 1'b1;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_ctl_stage.sv
// ID/EX boundary for the ALU control code with stall/flush, plus the EX-stage
// overflow trap and illegal-funct detection feeding back to the pipeline.
module alu_ctl_stage
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int CTL_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_ovf,
  input  logic               trap_ack,
  output logic [CTL_W-1:0]   ex_alu_ctl,
  output logic               ex_valid,
  output logic               ex_ovf_chk,
  output logic               ovf_trap,
  output logic               trap_pending,
  output logic               illegal_op
);

  logic [CTL_W-1:0] dec_code;
  logic             dec_chk;
  logic             dec_illegal;

  alu_ctl_decode #(
    .FUNCT_W (FUNCT_W),
    .CTL_W   (CTL_W)
  ) u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .code    (dec_code),
    .chk     (dec_chk),
    .illegal (dec_illegal)
  );

  logic [CTL_W-1:0] ctl_q, ctl_d;
  logic             valid_q, valid_d;
  logic             chk_q, chk_d;
  logic             ill_q, ill_d;
  logic             trap_q, trap_d;
  logic             ill_pulse_q, ill_pulse_d;
  logic             pend_q, pend_d;
  logic             det;
  logic             ill_det;

  // Events fire only when the EX instruction actually leaves, so a stalled
  // instruction is examined exactly once.
  assign det     = valid_q & chk_q & ex_ovf & ~stall;
  assign ill_det = valid_q & ill_q & ~stall;

  always_comb begin
    ctl_d   = ctl_q;
    valid_d = valid_q;
    chk_d   = chk_q;
    ill_d   = ill_q;
    if (flush) begin
      ctl_d   = '0;
      valid_d = 1'b0;
      chk_d   = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      ctl_d   = dec_code;
      valid_d = id_valid;
      chk_d   = dec_chk & id_valid;
      ill_d   = dec_illegal & id_valid;
    end
  end

  always_comb begin
    trap_d      = det;
    ill_pulse_d = ill_det;
    pend_d      = pend_q;
    if (det)
      pend_d = 1'b1;
    else if (trap_ack)
      pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q       <= '0;
      valid_q     <= 1'b0;
      chk_q       <= 1'b0;
      ill_q       <= 1'b0;
      trap_q      <= 1'b0;
      ill_pulse_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      ctl_q       <= ctl_d;
      valid_q     <= valid_d;
      chk_q       <= chk_d;
      ill_q       <= ill_d;
      trap_q      <= trap_d;
      ill_pulse_q <= ill_pulse_d;
      pend_q      <= pend_d;
    end
  end

  assign ex_alu_ctl   = ctl_q;
  assign ex_valid     = valid_q;
  assign ex_ovf_chk   = chk_q;
  assign ovf_trap     = trap_q;
  assign trap_pending = pend_q;
  assign illegal_op   = ill_pulse_q;

endmodule

// File: doc/alu_ctl_stage.md
Name: alu_ctl_stage

Overview:
- Producer end of the 4-bit ALU control interface consumed by the ALU bit-slices (ALUctl) and the MSB slice's overflow output.
- Decodes ALUOp/funct in ID, registers the resulting ALU control code into the ID/EX boundary with stall/flush, and captures the EX-stage overflow back into a sticky trap flag.
- Sits between the main control unit and the EX-stage ALU of the pipeline.

Parameters:
- FUNCT_W, 6, width of R-type funct field.
- CTL_W, 4, width of ALU control code.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- alu_op  input  2  ALUOp from main control
- funct  input  FUNCT_W  instruction funct field
- stall  input  1  hold ID/EX contents
- flush  input  1  insert bubble into EX
- ex_ovf  input  1  overflow from ALU MSB slice (EX, combinational)
- trap_ack  input  1  clears the pending trap
- ex_alu_ctl  output  CTL_W  ALU control code driving the ALU in EX
- ex_valid  output  1  EX holds a real instruction
- ex_ovf_chk  output  1  EX instruction traps on overflow
- ovf_trap  output  1  one-cycle pulse, overflow trap detected
- trap_pending  output  1  sticky trap flag
- illegal_op  output  1  one-cycle pulse, undefined funct reached EX

Behaviour:
- Async reset: ex_alu_ctl=0000, ex_valid=0, ex_ovf_chk=0, ovf_trap=0, trap_pending=0, illegal_op=0.
- Decode (combinational, ID):
  - alu_op 00 -> 0010 (add, lw/sw).
  - alu_op 01 -> 0110 (sub, beq).
  - alu_op 11 -> 0001 (or, ori).
  - alu_op 10, R-type by funct:
    - 100000 -> 0010, chk=1
    - 100010 -> 0110, chk=1
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - 100110 -> 1100
    - any other funct -> code 0000, chk=0, illegal=1.
  - chk=0 and illegal=0 for all non-R-type alu_op values.
- ID/EX register, one cycle latency, priority flush > stall > load:
  - flush: ex_valid=0, ex_alu_ctl=0000, ex_ovf_chk=0, internal ex_illegal=0.
  - stall (no flush): all EX registers hold their values.
  - otherwise: load the decode result. ex_valid=id_valid. chk and illegal are ANDed with id_valid; the code loads regardless.
- Trap detect:
  - det = ex_valid & ex_ovf_chk & ex_ovf & ~stall.
  - ovf_trap is registered: high exactly the cycle after det.
  - While stalled, no detection occurs. Detection happens once, on the cycle the instruction leaves EX.
- trap_pending:
  - Set on det. Cleared on trap_ack.
  - det and trap_ack in the same cycle: set wins.
  - A new det while already pending: remains 1, and ovf_trap still pulses.
- illegal_op: registered pulse, the cycle after (ex_valid & ex_illegal & ~stall).
- ex_ovf is ignored when ex_ovf_chk=0, e.g. slt, and, or, xor, lw address adds.
- Reset mid-stall or while pending: everything returns to reset values; no pulse is emitted on the first cycle after reset release.

Decomposition:
- Shared package alu_pkg:
  - ALU code constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_XOR=1100.
  - ALUOp constants.
  - funct constants.
- One combinational sub-module, alu_ctl_decode (alu_op, funct -> code, chk, illegal).
- The registered stage and trap logic live in alu_ctl_stage.

Test Plan:
- Decode sweep: id_valid=1, alu_op=10, each listed funct in turn, no stall/flush.
  - Next cycle ex_alu_ctl = 0010, 0110, 0000, 0001, 0111, 1100.
  - ex_ovf_chk=1 only for 100000 and 100010.
  - funct 000000 -> ex_alu_ctl=0000, illegal_op pulse one cycle later.
- Overflow trap: R-type add loaded, ex_ovf=1 -> ovf_trap=1 for exactly one cycle, trap_pending=1 until trap_ack. Same sequence with slt and ex_ovf=1 -> no trap.
- Stall/flush priority:
  - Load sub, then stall=1 for 3 cycles with ex_ovf=1 -> ex_alu_ctl holds 0110, no trap during stall, one trap pulse after stall drops.
  - stall=1 and flush=1 together -> ex_valid=0, ex_alu_ctl=0000.
- Ack collision: det and trap_ack in the same cycle -> trap_pending stays 1. A later trap_ack alone -> 0.
- Non-R-type: alu_op 00/01/11 with garbage funct -> 0010/0110/0001, chk=0, no illegal pulse. id_valid=0 with illegal funct -> no illegal pulse.
- Async reset asserted mid-stall with trap_pending=1 -> all outputs 0 immediately, without waiting for a clock edge.
